// File: rtl/rom_pkg.sv
// Shared definitions for the 556PT5/556PT4 ROM dump controller: chip constants,
// sequencer state encoding and the timer load helper.
package rom_pkg;

  localparam logic [7:0] CHIP_ID_IP3604 = 8'h04;
  localparam logic [7:0] CHIP_ID_IP3601 = 8'h01;

  localparam int IP3604_DATA_WIDTH    = 8;
  localparam int IP3601_DATA_WIDTH    = 4;
  localparam int IP3604_ADDRESS_WIDTH = 9;
  localparam int IP3601_ADDRESS_WIDTH = 8;

  localparam logic [3:0] READER_OP_CODE = 4'b1100;

  localparam int TIMER_WIDTH      = 8;
  localparam int ROM_RESET_CYCLES = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RST_ROM  = 3'd1,
    SETTLE   = 3'd2,
    CAPTURE  = 3'd3,
    OUTPUT   = 3'd4,
    INC_ON   = 3'd5,
    INC_WAIT = 3'd6,
    DONE     = 3'd7
  } dump_state_e;

  // A state that must last N cycles loads N-1 and leaves on the cycle the timer reads zero.
  function automatic logic [TIMER_WIDTH-1:0] timer_load_for(input int cycles);
    return TIMER_WIDTH'(cycles - 1);
  endfunction

endpackage

// File: rtl/rom_dump_timer.sv
// Loadable 8-bit down-counter shared by the timed states of the dump sequencer.
module rom_dump_timer
  import rom_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load,
  input  logic [TIMER_WIDTH-1:0] load_value,
  output logic [TIMER_WIDTH-1:0] value,
  output logic                   expired
);

  logic [TIMER_WIDTH-1:0] value_q;
  logic [TIMER_WIDTH-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_value;
    end else if (value_q != '0) begin
      value_d = value_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value   = value_q;
  assign expired = (value_q == '0);

endmodule

// File: rtl/rom_dump_sequencer.sv
// Walks the ROM reader through every address, capturing each word and handing it
// downstream over a valid/ready stream; address steps are confirmed on the reader bus.
module rom_dump_sequencer
  import rom_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDRESS_WIDTH  = 9,
  parameter int SETTLE_CYCLES  = 4,
  parameter int PULSE_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [ADDRESS_WIDTH-1:0] in_address,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     rom_reset_n,
  output logic                     rom_increment,
  output logic                     rom_decrement,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDRESS_WIDTH-1:0] out_address,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDRESS = '1;
  localparam logic [ADDRESS_WIDTH-1:0] ADDRESS_STEP = ADDRESS_WIDTH'(1);

  dump_state_e              state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] expected_q, expected_d;
  logic [ADDRESS_WIDTH-1:0] out_address_q, out_address_d;
  logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
  logic                     error_q, error_d;
  logic                     rom_reset_n_q, rom_reset_n_d;
  logic                     rom_increment_q, rom_increment_d;
  logic                     out_valid_q, out_valid_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [ADDRESS_WIDTH-1:0] expected_next;

  logic                   timer_load;
  logic [TIMER_WIDTH-1:0] timer_load_value;
  logic [TIMER_WIDTH-1:0] timer_value;
  logic                   timer_expired;

  rom_dump_timer u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (timer_load),
    .load_value (timer_load_value),
    .value      (timer_value),
    .expired    (timer_expired)
  );

  assign expected_next = expected_q + ADDRESS_STEP;

  always_comb begin
    state_d          = state_q;
    expected_d       = expected_q;
    out_address_d    = out_address_q;
    out_data_d       = out_data_q;
    error_d          = error_q;
    timer_load       = 1'b0;
    timer_load_value = '0;

    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            error_d          = 1'b0;
            expected_d       = '0;
            state_d          = RST_ROM;
            timer_load       = 1'b1;
            timer_load_value = timer_load_for(ROM_RESET_CYCLES);
          end
        end
        RST_ROM: begin
          if (timer_expired) begin
            state_d          = SETTLE;
            timer_load       = 1'b1;
            timer_load_value = timer_load_for(SETTLE_CYCLES);
          end
        end
        SETTLE: begin
          if (timer_expired) begin
            state_d = CAPTURE;
          end
        end
        CAPTURE: begin
          out_data_d    = in_data;
          out_address_d = expected_q;
          if (in_address != expected_q) begin
            error_d = 1'b1;
          end
          state_d = OUTPUT;
        end
        OUTPUT: begin
          // The last word ends the dump without stepping, so reader wrap never matters.
          if (out_ready) begin
            if (expected_q == LAST_ADDRESS) begin
              state_d = DONE;
            end else begin
              state_d          = INC_ON;
              timer_load       = 1'b1;
              timer_load_value = timer_load_for(PULSE_CYCLES);
            end
          end
        end
        INC_ON: begin
          if (timer_expired) begin
            state_d          = INC_WAIT;
            timer_load       = 1'b1;
            timer_load_value = timer_load_for(TIMEOUT_CYCLES);
          end
        end
        INC_WAIT: begin
          if (in_address == expected_next) begin
            expected_d       = expected_next;
            state_d          = SETTLE;
            timer_load       = 1'b1;
            timer_load_value = timer_load_for(SETTLE_CYCLES);
          end else if (timer_value == '0) begin
            error_d = 1'b1;
            state_d = DONE;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // Outputs are registered from the next state so they settle one edge after any decision.
    rom_reset_n_d   = (state_d != RST_ROM);
    rom_increment_d = (state_d == INC_ON);
    out_valid_d     = (state_d == OUTPUT);
    busy_d          = (state_d != IDLE);
    done_d          = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      expected_q      <= '0;
      out_address_q   <= '0;
      out_data_q      <= '0;
      error_q         <= 1'b0;
      rom_reset_n_q   <= 1'b0;
      rom_increment_q <= 1'b0;
      out_valid_q     <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      expected_q      <= expected_d;
      out_address_q   <= out_address_d;
      out_data_q      <= out_data_d;
      error_q         <= error_d;
      rom_reset_n_q   <= rom_reset_n_d;
      rom_increment_q <= rom_increment_d;
      out_valid_q     <= out_valid_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  assign rom_reset_n   = rom_reset_n_q;
  assign rom_increment = rom_increment_q;
  assign rom_decrement = 1'b0;
  assign out_valid     = out_valid_q;
  assign out_address   = out_address_q;
  assign out_data      = out_data_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;

endmodule

// File: tb/tb_rom_dump_sequencer.sv
// Self-checking bench: behavioural reader/ROM model plus a word scoreboard built
// from the ROM contents, exercising dump, backpressure, timeout, mismatch, abort and reset.
module tb_rom_dump_sequencer;

  localparam int AW      = 3;
  localparam int DW      = 4;
  localparam int SETTLE  = 4;
  localparam int PULSE   = 2;
  localparam int TIMEOUT = 16;
  localparam int DEPTH   = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] in_address;
  logic [DW-1:0] in_data;
  logic          rom_reset_n, rom_increment, rom_decrement;
  logic          out_valid, out_ready, busy, done, error;
  logic [AW-1:0] out_address;
  logic [DW-1:0] out_data;

  logic          ready_manual = 1'b1;
  logic          rand_ready_en = 1'b0;
  logic          rand_bit = 1'b1;
  logic          force_en = 1'b0;
  logic [AW-1:0] force_val = '0;
  logic          stall_en = 1'b0;
  logic [AW-1:0] stall_at = '0;
  logic [AW-1:0] model_addr = '0;
  logic          inc_prev = 1'b0;
  logic [DW-1:0] rom_mem [DEPTH];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [AW-1:0] got_addr [$];
  logic [DW-1:0] got_data [$];

  always #5 clk = ~clk;

  rom_dump_sequencer #(
    .DATA_WIDTH     (DW),
    .ADDRESS_WIDTH  (AW),
    .SETTLE_CYCLES  (SETTLE),
    .PULSE_CYCLES   (PULSE),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .abort         (abort),
    .in_address    (in_address),
    .in_data       (in_data),
    .rom_reset_n   (rom_reset_n),
    .rom_increment (rom_increment),
    .rom_decrement (rom_decrement),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_address   (out_address),
    .out_data      (out_data),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  assign out_ready  = rand_ready_en ? rand_bit : ready_manual;
  assign in_address = force_en ? force_val : model_addr;
  assign in_data    = rom_mem[model_addr];

  // Reader model: one step per rising edge of the increment request, held at 0 by its reset.
  always @(posedge clk) begin
    if (!rom_reset_n) begin
      model_addr <= '0;
    end else if (rom_increment && !inc_prev && !(stall_en && model_addr >= stall_at)) begin
      model_addr <= model_addr + 1'b1;
    end
    inc_prev <= rom_increment;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1 rand_bit = 1'($urandom_range(0, 1));
    end
  end

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready && !abort) begin
      got_addr.push_back(out_address);
      got_data.push_back(out_data);
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({rom_reset_n, rom_increment, rom_decrement, out_valid, busy, done, error} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: actual %b, required 0000000", {rom_reset_n, rom_increment, rom_decrement, out_valid, busy, done, error});
    end
    checks++;
    if (out_address !== '0 || out_data !== '0) begin
      errors++;
      $display("[TB] FAIL reset_word: actual (%0h,%0h), required (0,0)", out_address, out_data);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rom_reset_n !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: actual rom_reset_n=%b busy=%b, required 1 0", rom_reset_n, busy);
    end
  endtask

  task automatic test_full_dump();
    logic [DW-1:0] exp_data [DEPTH];
    int base, dbase;
    bit ok;
    exp_data = '{4'hA, 4'hB, 4'h8, 4'h9, 4'hE, 4'hF, 4'hC, 4'hD};
    for (int a = 0; a < DEPTH; a++) rom_mem[a] = DW'(a) ^ 4'hA;
    rand_ready_en = 1'b0;
    ready_manual  = 1'b1;
    base  = got_addr.size();
    dbase = done_cnt;
    pulse_start();
    wait_done(2000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL full_dump_done: actual no done in 2000 cycles, required done");
    end
    repeat (3) @(negedge clk);
    checks++;
    if (got_addr.size() - base !== DEPTH) begin
      errors++;
      $display("[TB] FAIL full_dump_count: actual %0d, required %0d", got_addr.size() - base, DEPTH);
    end
    for (int i = 0; i < DEPTH && base + i < got_addr.size(); i++) begin
      checks++;
      if (got_addr[base+i] !== AW'(i) || got_data[base+i] !== exp_data[i]) begin
        errors++;
        $display("[TB] FAIL full_dump_word%0d: actual (%0h,%0h), required (%0h,%0h)", i, got_addr[base+i], got_data[base+i], i, exp_data[i]);
      end
    end
    checks++;
    if (done_cnt - dbase !== 1 || error !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_dump_end: actual done_pulses=%0d error=%b busy=%b, required 1 0 0", done_cnt - dbase, error, busy);
    end
  endtask

  task automatic test_backpressure();
    int base, stable_bad, inc_bad;
    bit ok;
    for (int a = 0; a < DEPTH; a++) rom_mem[a] = DW'(a) ^ 4'hA;
    ready_manual = 1'b1;
    base = got_addr.size();
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (out_valid && out_ready && out_address == AW'(2)) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1 ready_manual = 1'b0;
    for (int i = 0; i < 200 && ok; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    stable_bad = 0;
    inc_bad    = 0;
    for (int i = 0; i < 20; i++) begin
      if (!(out_valid === 1'b1 && out_address === AW'(3) && out_data === 4'h9)) stable_bad++;
      if (rom_increment !== 1'b0) inc_bad++;
      @(negedge clk);
    end
    checks++;
    if (!ok || stable_bad != 0) begin
      errors++;
      $display("[TB] FAIL backpressure_hold: actual %0d unstable cycles (last %b,%0h,%0h), required 0 (1,3,9)", stable_bad, out_valid, out_address, out_data);
    end
    checks++;
    if (inc_bad != 0) begin
      errors++;
      $display("[TB] FAIL backpressure_no_step: actual %0d increment cycles, required 0", inc_bad);
    end
    @(posedge clk);
    #1 ready_manual = 1'b1;
    wait_done(2000, ok);
    repeat (2) @(negedge clk);
    checks++;
    if (!ok || got_addr.size() - base !== DEPTH) begin
      errors++;
      $display("[TB] FAIL backpressure_count: actual %0d words, required %0d", got_addr.size() - base, DEPTH);
    end
    for (int i = 0; i < DEPTH && base + i < got_addr.size(); i++) begin
      checks++;
      if (got_addr[base+i] !== AW'(i) || got_data[base+i] !== rom_mem[i]) begin
        errors++;
        $display("[TB] FAIL backpressure_word%0d: actual (%0h,%0h), required (%0h,%0h)", i, got_addr[base+i], got_data[base+i], i, rom_mem[i]);
      end
    end
  endtask

  task automatic test_timeout();
    int base;
    bit ok, prev_inc;
    logic err_before, err_after, done_after;
    for (int a = 0; a < DEPTH; a++) rom_mem[a] = DW'($urandom);
    stall_en = 1'b1;
    stall_at = AW'(5);
    base = got_addr.size();
    pulse_start();
    ok = 1'b0;
    prev_inc = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (prev_inc && !rom_increment && got_addr.size() - base == 6) begin
        ok = 1'b1;
        break;
      end
      prev_inc = rom_increment;
    end
    repeat (TIMEOUT - 1) @(negedge clk);
    err_before = error;
    @(negedge clk);
    err_after  = error;
    done_after = done;
    checks++;
    if (!ok || err_before !== 1'b0 || err_after !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_error_timing: actual before=%b after=%b, required 0 1", err_before, err_after);
    end
    checks++;
    if (done_after !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_done: actual %b, required 1", done_after);
    end
    checks++;
    if (got_addr.size() - base !== 6 || got_addr[got_addr.size()-1] !== AW'(5) || got_data[got_data.size()-1] !== rom_mem[5]) begin
      errors++;
      $display("[TB] FAIL timeout_last_word: actual %0d words last addr %0h, required 6 words last addr 5", got_addr.size() - base, got_addr[got_addr.size()-1]);
    end
    stall_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_mismatch();
    int base;
    bit ok, prev_inc;
    for (int a = 0; a < DEPTH; a++) rom_mem[a] = DW'($urandom);
    ready_manual = 1'b1;
    base = got_addr.size();
    pulse_start();
    ok = 1'b0;
    prev_inc = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (prev_inc && !rom_increment && got_addr.size() - base == 1) begin
        ok = 1'b1;
        break;
      end
      prev_inc = rom_increment;
    end
    @(posedge clk);
    #1 force_val = AW'(2);
    force_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    force_en = 1'b0;
    checks++;
    if (!ok || out_address !== AW'(1) || out_data !== rom_mem[1] || error !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mismatch_word: actual (%0h,%0h) error=%b, required (1,%0h) error=1", out_address, out_data, error, rom_mem[1]);
    end
    wait_done(2000, ok);
    repeat (2) @(negedge clk);
    checks++;
    if (!ok || got_addr.size() - base !== DEPTH || error !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mismatch_sticky: actual %0d words error=%b, required %0d words error=1", got_addr.size() - base, error, DEPTH);
    end
    pulse_start();
    @(negedge clk);
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mismatch_clear_on_start: actual %b, required 0", error);
    end
    wait_done(2000, ok);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_abort();
    int base, dbase, low_cycles;
    bit ok;
    for (int a = 0; a < DEPTH; a++) rom_mem[a] = DW'($urandom);
    ready_manual = 1'b1;
    base  = got_addr.size();
    dbase = done_cnt;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (rom_increment && got_addr.size() - base == 5) begin
        ok = 1'b1;
        break;
      end
    end
    abort = 1'b1;
    @(negedge clk);
    checks++;
    if (!ok || {busy, rom_increment, out_valid, done} !== 4'b0) begin
      errors++;
      $display("[TB] FAIL abort_outputs: actual busy,inc,valid,done=%b, required 0000", {busy, rom_increment, out_valid, done});
    end
    @(posedge clk);
    #1 abort = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (done_cnt != dbase) begin
      errors++;
      $display("[TB] FAIL abort_no_done: actual %0d pulses, required 0", done_cnt - dbase);
    end
    base = got_addr.size();
    pulse_start();
    low_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!rom_reset_n) low_cycles++;
    end
    checks++;
    if (low_cycles != 2) begin
      errors++;
      $display("[TB] FAIL abort_restart_reset: actual %0d low cycles, required 2", low_cycles);
    end
    wait_done(2000, ok);
    repeat (2) @(negedge clk);
    checks++;
    if (!ok || got_addr.size() - base !== DEPTH || got_addr[base] !== '0) begin
      errors++;
      $display("[TB] FAIL abort_restart_dump: actual %0d words, required %0d from address 0", got_addr.size() - base, DEPTH);
    end
  endtask

  task automatic test_random_dump();
    int base;
    bit ok;
    for (int iter = 0; iter < 3; iter++) begin
      for (int a = 0; a < DEPTH; a++) rom_mem[a] = DW'($urandom);
      rand_ready_en = 1'b1;
      base = got_addr.size();
      pulse_start();
      wait_done(4000, ok);
      rand_ready_en = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (!ok || got_addr.size() - base !== DEPTH || error !== 1'b0) begin
        errors++;
        $display("[TB] FAIL random_dump%0d_count: actual %0d words error=%b, required %0d error=0", iter, got_addr.size() - base, error, DEPTH);
      end
      for (int i = 0; i < DEPTH && base + i < got_addr.size(); i++) begin
        checks++;
        if (got_addr[base+i] !== AW'(i) || got_data[base+i] !== rom_mem[i]) begin
          errors++;
          $display("[TB] FAIL random_dump%0d_word%0d: actual (%0h,%0h), required (%0h,%0h)", iter, i, got_addr[base+i], got_data[base+i], i, rom_mem[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_dump();
    int base;
    bit ok;
    ready_manual = 1'b0;
    base = got_addr.size();
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (!ok || {out_valid, rom_reset_n, busy} !== 3'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_outputs: actual valid,rom_reset_n,busy=%b, required 000", {out_valid, rom_reset_n, busy});
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    ready_manual = 1'b1;
    repeat (100) @(negedge clk);
    checks++;
    if (got_addr.size() != base || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_quiet: actual %0d words busy=%b, required 0 words busy=0", got_addr.size() - base, busy);
    end
  endtask

  initial begin
    for (int a = 0; a < DEPTH; a++) rom_mem[a] = '0;
    repeat (3) @(posedge clk);
    test_reset();
    test_full_dump();
    test_backpressure();
    test_timeout();
    test_mismatch();
    test_abort();
    test_random_dump();
    test_reset_mid_dump();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_dump_sequencer.md
Name: rom_dump_sequencer

Overview:
- Automatic controller that sequences the ROM reader to dump a complete 556PT5/556PT4 image without manual address buttons.
- Resets the reader, then for every address: waits for chip/data-register settle, captures address+data, and hands the word to a downstream sink (UART/FIFO) over a valid/ready stream.
- Steps the reader using increment pulses and confirms each step by watching the reader's address bus.

Parameters:
DATA_WIDTH, 8, ROM data width (8 for 3604, 4 for 3601)
ADDRESS_WIDTH, 9, ROM address width (9 for 3604, 8 for 3601); dump depth = 2**ADDRESS_WIDTH
SETTLE_CYCLES, 4, clk cycles waited after an address becomes valid before capture; legal range 2..255
PULSE_CYCLES, 2, clk cycles rom_increment is held high per step; legal range 1..255
TIMEOUT_CYCLES, 16, max cycles to wait for the reader address to advance; legal range 4..255

Ports:
clk  in  1  clock
reset_n  in  1  synchronous, active-low reset
start  in  1  level; sampled in IDLE only
abort  in  1  level; returns to IDLE from any state
in_address  in  ADDRESS_WIDTH  address bus from reader
in_data  in  DATA_WIDTH  registered data bus from reader
rom_reset_n  out  1  reset to reader, active-low
rom_increment  out  1  increment request to reader
rom_decrement  out  1  decrement request to reader; constant 0
out_valid  out  1  stream valid
out_ready  in  1  stream ready from sink
out_address  out  ADDRESS_WIDTH  address of current word
out_data  out  DATA_WIDTH  captured data
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on completion or abort-free error stop
error  out  1  sticky; cleared by reset_n or next accepted start

Behaviour:
- Reset values: state IDLE; rom_reset_n=0; rom_increment=0; out_valid=0; out_address=0; out_data=0; busy=0; done=0; error=0; expected address=0; cycle counter=0.
- IDLE: rom_reset_n=1. On start=1, clear error, set expected=0, go to RST_ROM.
- RST_ROM: drive rom_reset_n=0 for exactly 2 cycles, then go to SETTLE.
- SETTLE: count SETTLE_CYCLES cycles, then go to CAPTURE.
- CAPTURE (1 cycle):
  - Latch in_data into out_data and expected into out_address.
  - If in_address != expected, set error.
  - Go to OUTPUT.
- OUTPUT:
  - out_valid=1. out_data/out_address stay stable until out_ready=1.
  - Transfer occurs on a cycle with out_valid&out_ready. out_valid drops the next cycle.
  - After the transfer: if expected == 2**ADDRESS_WIDTH-1, go to DONE; otherwise go to INC_ON.
- INC_ON: rom_increment=1 for PULSE_CYCLES cycles, then go to INC_WAIT.
- INC_WAIT:
  - rom_increment=0.
  - If in_address == expected+1 (ADDRESS_WIDTH-bit wrap arithmetic), increment expected and go to SETTLE.
  - If TIMEOUT_CYCLES elapse first, set error and go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- Throughput: one word per (PULSE_CYCLES + reader step latency + SETTLE_CYCLES + 1 + handshake) cycles minimum.
- Boundary conditions:
  - Last address: no increment is issued after word 2**ADDRESS_WIDTH-1. The reader is left at the last address; the sequencer never relies on reader wrap.
  - abort=1 in any state: next state IDLE; rom_increment and out_valid drop the next cycle; done is not pulsed; a word mid-handshake is dropped. abort has priority over start and over out_ready in the same cycle.
  - start while busy: ignored.
  - reset_n low mid-dump: all outputs return to reset values the next edge. rom_reset_n=0 also holds the reader in reset.
  - out_ready held low: wait indefinitely in OUTPUT; no timeout applies.
  - rom_decrement: constantly 0, so the reader's simultaneous-request rejection never triggers.
- Counters are 8 bits wide; expected is ADDRESS_WIDTH bits wide.

Decomposition:
- Shared package rom_pkg holds:
  - chip-type constants: IP3604/IP3601 IDs, data widths 8/4, address widths 9/8
  - state encoding localparams: IDLE, RST_ROM, SETTLE, CAPTURE, OUTPUT, INC_ON, INC_WAIT, DONE
  - the reader operation code 4'b1100
- One natural sub-module: rom_dump_timer. It is a loadable 8-bit down-counter with load, value and expired, shared by the SETTLE, INC_ON, INC_WAIT and RST_ROM states.
- The integration bench instantiates the existing reader plus a behavioural ROM model.

Test Plan:
- Full dump. Config: ADDRESS_WIDTH=3, DATA_WIDTH=4, ROM model data = addr^4'hA, out_ready=1, pulse start. Required: 8 words (0,A),(1,B),(2,8),(3,9),(4,E),(5,F),(6,C),(7,D) in order, then done pulses once, error=0, busy=0.
- Backpressure. Hold out_ready=0 for 20 cycles at word 3. Required: out_valid stays 1; out_address=3 and out_data=9 stay stable; no rom_increment pulse occurs until the transfer.
- Step timeout. Reader model ignores increments after address 5. Required: error=1 TIMEOUT_CYCLES cycles after INC_WAIT entry, done pulses, last emitted word is address 5.
- Address mismatch. Force in_address=2 while expected=1 at CAPTURE. Required: error=1 and the word is still emitted with out_address=1. A later start clears error.
- Abort. Assert abort during INC_ON of word 4. Required: next cycle busy=0, rom_increment=0, out_valid=0, no done pulse. A subsequent start restarts from address 0 with a 2-cycle rom_reset_n low.
- Reset mid-dump. Pull reset_n low in OUTPUT. Required: out_valid=0, rom_reset_n=0, busy=0 after one edge; no further words emitted.
